// File: rtl/reset_sequencer.sv
// Sequenced reset release for the display pipeline: filters clock-generator lock,
// holds every domain in reset, then releases the domains one at a time from bit 0 up.
module reset_sequencer #(
    parameter int NUM_STAGES  = 3,
    parameter int LOCK_FILTER = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_locked,
    input  logic                  i_soft_rst,
    output logic [NUM_STAGES-1:0] o_rst,
    output logic                  o_ready
);

    localparam int MAX_HG    = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int MAX_COUNT = (MAX_HG > LOCK_FILTER) ? MAX_HG : LOCK_FILTER;
    localparam int CW        = $clog2(MAX_COUNT + 1);

    localparam logic [CW-1:0] FILTER_LAST = CW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(STAGE_GAP - 1);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_WAIT_LOCK,
        ST_HOLD,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t                state, state_d;
    logic [CW-1:0]         count, count_d;
    logic [CW-1:0]         step_last;
    logic [NUM_STAGES-1:0] stages, stages_d, stages_shift;
    logic                  ready, ready_d;
    logic                  lock_s1, lock_sync;

    // i_locked comes from another clock domain; two flops before anything looks at it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lock_s1   <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            // NOTE: non-blocking so each flop samples the value from before the edge.
            lock_s1   <= i_locked;
            lock_sync <= lock_s1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= ST_RESET;
            count  <= '0;
            stages <= '1;
            ready  <= 1'b0;
        end else begin
            state  <= state_d;
            count  <= count_d;
            stages <= stages_d;
            ready  <= ready_d;
        end
    end

    // Released bits stay contiguous from bit 0, so releasing one more is a left shift.
    assign stages_shift = stages << 1;
    assign step_last    = (state == ST_HOLD) ? HOLD_LAST : GAP_LAST;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_d  = state;
        count_d  = count;
        stages_d = stages;

        case (state)
            ST_RESET: begin
                state_d  = ST_WAIT_LOCK;
                count_d  = '0;
                stages_d = '1;
            end

            ST_WAIT_LOCK: begin
                stages_d = '1;
                if (!lock_sync) begin
                    count_d = '0;
                end else if (count == FILTER_LAST) begin
                    state_d = ST_HOLD;
                    count_d = '0;
                end else begin
                    count_d = count + 1'b1;
                end
            end

            ST_HOLD, ST_RELEASE, ST_RUN: begin
                if (!lock_sync) begin
                    state_d  = ST_WAIT_LOCK;
                    count_d  = '0;
                    stages_d = '1;
                end else if (i_soft_rst) begin
                    state_d  = ST_HOLD;
                    count_d  = '0;
                    stages_d = '1;
                end else if (state != ST_RUN) begin
                    if (count == step_last) begin
                        count_d  = '0;
                        stages_d = stages_shift;
                        state_d  = (stages_shift == '0) ? ST_RUN : ST_RELEASE;
                    end else begin
                        count_d = count + 1'b1;
                    end
                end
            end

            default: begin
                state_d  = ST_RESET;
                count_d  = '0;
                stages_d = '1;
            end
        endcase

        ready_d = (state_d == ST_RUN);
    end

    assign o_rst   = stages;
    assign o_ready = ready;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: two configurations driven in lockstep and compared each
// edge against a timestamp model of lock filtering, hold time and staged release.
module tb_reset_sequencer;

    localparam int NA = 3, HA = 16, GA = 8;
    localparam int NB = 1, HB = 1,  GB = 1;
    localparam int LF = 4;
    localparam int OW = NA + NB + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          locked = 1'b0;
    logic          soft_rst = 1'b0;
    logic [NA-1:0] rst_a;
    logic          ready_a;
    logic [NB-1:0] rst_b;
    logic          ready_b;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_STAGES(NA), .LOCK_FILTER(LF), .HOLD_CYCLES(HA), .STAGE_GAP(GA)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .i_locked(locked), .i_soft_rst(soft_rst),
        .o_rst(rst_a), .o_ready(ready_a)
    );

    reset_sequencer #(
        .NUM_STAGES(NB), .LOCK_FILTER(LF), .HOLD_CYCLES(HB), .STAGE_GAP(GB)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_locked(locked), .i_soft_rst(soft_rst),
        .o_rst(rst_b), .o_ready(ready_b)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: edge count since reset, raw lock history, and for each
    // configuration whether a hold is armed and the edge on which it began.
    int edge_n;
    bit lock_hist[$];
    bit armed [2];
    int entry [2];
    int lock_run;

    // Expected o_rst edges for the default configuration with lock held from reset.
    localparam int N_DIR = 8;
    int         dir_edge [N_DIR] = '{5, 6, 21, 22, 29, 30, 37, 38};
    logic [2:0] dir_rst  [N_DIR] = '{3'b111, 3'b111, 3'b111, 3'b110,
                                     3'b110, 3'b100, 3'b100, 3'b000};

    function automatic void model_clear();
        edge_n   = 0;
        lock_run = 0;
        lock_hist.delete();
        for (int d = 0; d < 2; d++) begin
            armed[d] = 1'b0;
            entry[d] = 0;
        end
    endfunction

    function automatic void model_edge(input bit lk, input bit sr);
        bit ls;
        edge_n++;
        // Logic only sees i_locked as it was two edges earlier.
        ls = (lock_hist.size() >= 2) ? lock_hist[lock_hist.size() - 2] : 1'b0;
        lock_hist.push_back(lk);
        if (lock_hist.size() > 4) void'(lock_hist.pop_front());
        if (!armed[0]) begin
            lock_run = ls ? lock_run + 1 : 0;
            if (lock_run == LF) begin
                for (int d = 0; d < 2; d++) begin
                    armed[d] = 1'b1;
                    entry[d] = edge_n;
                end
            end
        end else if (!ls) begin
            lock_run = 0;
            for (int d = 0; d < 2; d++) armed[d] = 1'b0;
        end else if (sr) begin
            for (int d = 0; d < 2; d++) entry[d] = edge_n;
        end
    endfunction

    function automatic int released(input int d, input int num, input int h, input int g);
        int el;
        int r;
        if (!armed[d]) return 0;
        el = edge_n - entry[d];
        if (el < h) return 0;
        r = (el - h) / g + 1;
        return (r > num) ? num : r;
    endfunction

    function automatic logic [OW-1:0] expected();
        logic [NA-1:0] ea;
        logic [NB-1:0] eb;
        int ra, rb;
        ra = released(0, NA, HA, GA);
        rb = released(1, NB, HB, GB);
        for (int i = 0; i < NA; i++) ea[i] = (i >= ra);
        for (int i = 0; i < NB; i++) eb[i] = (i >= rb);
        return {ea, ra == NA, eb, rb == NB};
    endfunction

    function automatic logic [OW-1:0] observed();
        return {rst_a, ready_a, rst_b, ready_b};
    endfunction

    task automatic step(input bit lk, input bit sr);
        locked   = lk;
        soft_rst = sr;
        @(posedge clk);
        model_edge(lk, sr);
        #1;
    endtask

    task automatic apply_reset(input bit lk);
        rst      = 1'b1;
        locked   = lk;
        soft_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic run_default_sequence(input string tag, input int n_edges);
        repeat (n_edges) begin
            step(1'b1, 1'b0);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL %s_model edge=%0d got=%b want=%b", tag, edge_n, observed(), expected());
            end
            for (int k = 0; k < N_DIR; k++) begin
                if (edge_n == dir_edge[k]) begin
                    checks++;
                    if ({rst_a, ready_a} !== {dir_rst[k], dir_rst[k] == 3'b000}) begin
                        errors++;
                        $display("FAIL %s_timing edge=%0d got=%b want=%b", tag, edge_n,
                                 {rst_a, ready_a}, {dir_rst[k], dir_rst[k] == 3'b000});
                    end
                end
            end
            if (edge_n == 6 || edge_n == 7) begin
                checks++;
                if ({rst_b, ready_b} !== ((edge_n == 7) ? 2'b01 : 2'b10)) begin
                    errors++;
                    $display("FAIL %s_single_stage edge=%0d got=%b want=%b", tag, edge_n,
                             {rst_b, ready_b}, (edge_n == 7) ? 2'b01 : 2'b10);
                end
            end
        end
    endtask

    task automatic test_reset();
        locked = 1'b1;
        rst    = 1'b1;
        #1;
        checks++;
        if (observed() !== {3'b111, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_async got=%b want=%b", observed(), {3'b111, 1'b0, 1'b1, 1'b0});
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (observed() !== {3'b111, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_held got=%b want=%b", observed(), {3'b111, 1'b0, 1'b1, 1'b0});
        end
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_defaults();
        run_default_sequence("defaults", 45);
    endtask

    task automatic test_async_reset();
        apply_reset(1'b1);
        run_default_sequence("pre_async", 25);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (observed() !== {3'b111, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_assert got=%b want=%b", observed(), {3'b111, 1'b0, 1'b1, 1'b0});
        end
        apply_reset(1'b1);
        run_default_sequence("after_async", 45);
    endtask

    task automatic test_lock_glitch();
        bit lk;
        apply_reset(1'b0);
        repeat (60) begin
            lk = (edge_n + 1 >= 10) && (edge_n + 1 != 12);
            step(lk, 1'b0);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL glitch_model edge=%0d got=%b want=%b", edge_n, observed(), expected());
            end
            if (edge_n <= 34) begin
                checks++;
                if (rst_a !== ((edge_n == 34) ? 3'b110 : 3'b111)) begin
                    errors++;
                    $display("FAIL glitch_hold edge=%0d got=%b want=%b", edge_n, rst_a,
                             (edge_n == 34) ? 3'b110 : 3'b111);
                end
            end
            if (edge_n == 18 || edge_n == 19) begin
                checks++;
                if (rst_b !== ((edge_n == 19) ? 1'b0 : 1'b1)) begin
                    errors++;
                    $display("FAIL glitch_single_stage edge=%0d got=%b want=%b", edge_n, rst_b,
                             (edge_n == 19) ? 1'b0 : 1'b1);
                end
            end
        end
    endtask

    task automatic test_lock_drop_run();
        int d;
        int r;
        apply_reset(1'b1);
        run_default_sequence("pre_drop", 40);
        d = edge_n + 1;
        repeat (6) begin
            step(1'b0, 1'b0);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL drop_model edge=%0d got=%b want=%b", edge_n, observed(), expected());
            end
            if (edge_n <= d + 2) begin
                checks++;
                if ({rst_a, ready_a} !== ((edge_n == d + 2) ? 4'b1110 : 4'b0001)) begin
                    errors++;
                    $display("FAIL drop_latency edge=+%0d got=%b want=%b", edge_n - d,
                             {rst_a, ready_a}, (edge_n == d + 2) ? 4'b1110 : 4'b0001);
                end
            end
        end
        r = edge_n + 1;
        repeat (45) begin
            step(1'b1, 1'b0);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL relock_model edge=%0d got=%b want=%b", edge_n, observed(), expected());
            end
            if (edge_n == r + 20 || edge_n == r + 21 || edge_n == r + 37) begin
                checks++;
                if ({rst_a, ready_a} !== ((edge_n == r + 20) ? 4'b1110 :
                                          (edge_n == r + 21) ? 4'b1100 : 4'b0001)) begin
                    errors++;
                    $display("FAIL relock_timing edge=+%0d got=%b", edge_n - r, {rst_a, ready_a});
                end
            end
        end
    endtask

    task automatic test_soft_rst();
        int s;
        int r;
        bit sr;
        apply_reset(1'b1);
        run_default_sequence("pre_soft", 40);
        s = edge_n + 1;
        repeat (40) begin
            step(1'b1, edge_n + 1 == s);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL soft_model edge=%0d got=%b want=%b", edge_n, observed(), expected());
            end
            if (edge_n == s || edge_n == s + 15 || edge_n == s + 16 ||
                edge_n == s + 31 || edge_n == s + 32) begin
                checks++;
                if ({rst_a, ready_a} !== ((edge_n <= s + 15) ? 4'b1110 :
                                          (edge_n == s + 16) ? 4'b1100 :
                                          (edge_n == s + 31) ? 4'b1000 : 4'b0001)) begin
                    errors++;
                    $display("FAIL soft_timing edge=+%0d got=%b", edge_n - s, {rst_a, ready_a});
                end
            end
        end
        // Held request keeps restarting the hold; then a pulse during lock filtering.
        repeat (5) step(1'b1, 1'b1);
        repeat (30) begin
            step(1'b1, 1'b0);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL soft_held edge=%0d got=%b want=%b", edge_n, observed(), expected());
            end
        end
        repeat (4) step(1'b0, 1'b0);
        r = edge_n + 1;
        repeat (30) begin
            sr = (edge_n + 1 == r + 1) || (edge_n + 1 == r + 3);
            step(1'b1, sr);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL soft_wait_model edge=%0d got=%b want=%b", edge_n, observed(), expected());
            end
            if (edge_n == r + 20 || edge_n == r + 21) begin
                checks++;
                if (rst_a !== ((edge_n == r + 21) ? 3'b110 : 3'b111)) begin
                    errors++;
                    $display("FAIL soft_in_wait edge=+%0d got=%b", edge_n - r, rst_a);
                end
            end
        end
    endtask

    task automatic test_lock_and_soft();
        int d;
        apply_reset(1'b1);
        run_default_sequence("pre_both", 25);
        d = edge_n + 1;
        repeat (30) begin
            step(edge_n + 1 != d, edge_n + 1 == d + 2);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL both_model edge=%0d got=%b want=%b", edge_n, observed(), expected());
            end
            if (edge_n == d + 2 || edge_n == d + 18 || edge_n == d + 22) begin
                checks++;
                if (rst_a !== ((edge_n == d + 22) ? 3'b110 : 3'b111)) begin
                    errors++;
                    $display("FAIL both_priority edge=+%0d got=%b", edge_n - d, rst_a);
                end
            end
        end
    endtask

    task automatic test_random();
        bit lk;
        bit sr;
        for (int round = 0; round < 3; round++) begin
            apply_reset(1'b1);
            lk = 1'b1;
            repeat (600) begin
                if (lk) lk = ($urandom_range(79) != 0);
                else    lk = ($urandom_range(3) == 0);
                sr = ($urandom_range(59) == 0);
                step(lk, sr);
                checks++;
                if (observed() !== expected()) begin
                    errors++;
                    $display("FAIL random_model round=%0d edge=%0d got=%b want=%b",
                             round, edge_n, observed(), expected());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_async_reset();
        test_lock_glitch();
        test_lock_drop_run();
        test_soft_rst();
        test_lock_and_soft();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
